// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU (alu_seq and alu_iter_unit).
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_NOT  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_PASS = 4'd8,
    OP_MUL  = 4'd9
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_V = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } alu_state_t;

  localparam logic [1:0] ITER_SHL = 2'd0;
  localparam logic [1:0] ITER_SHR = 2'd1;
  localparam logic [1:0] ITER_MUL = 2'd2;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine: one-bit-per-cycle shifts and, with ALU_MUL_EN, a shift-add multiply.
// done pulses on the cycle of the final step; result/carry then show that step's outcome.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [CW-1:0] cnt_init,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          carry
);

  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          run_q, run_d;
  logic          c_q, c_d;
`ifdef ALU_MUL_EN
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N:0]    sum;
`endif

  always_comb begin
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    run_d  = run_q;
    c_d    = c_q;
`ifdef ALU_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    sum     = '0;
`endif
    if (start) begin
      // The multiply walks the multiplier through lo; shifts walk the operand itself.
      lo_d   = (mode == ITER_MUL) ? b : a;
      cnt_d  = cnt_init;
      mode_d = mode;
      run_d  = 1'b1;
      c_d    = 1'b0;
`ifdef ALU_MUL_EN
      hi_d    = '0;
      mcand_d = a;
`endif
    end else if (run_q) begin
      case (mode_q)
        ITER_SHL: begin
          c_d  = lo_q[N-1];
          lo_d = {lo_q[N-2:0], 1'b0};
        end
        ITER_SHR: begin
          c_d  = lo_q[0];
          lo_d = {1'b0, lo_q[N-1:1]};
        end
`ifdef ALU_MUL_EN
        ITER_MUL: begin
          sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
          {hi_d, lo_d} = {sum, lo_q[N-1:1]};
        end
`endif
        default: ;
      endcase
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  assign done   = run_q && (cnt_q == CW'(1));
  assign result = lo_d;
`ifdef ALU_MUL_EN
  assign carry  = (mode_q == ITER_MUL) ? (|hi_d) : c_d;
`else
  assign carry  = c_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= ITER_SHL;
      run_q   <= 1'b0;
      c_q     <= 1'b0;
`ifdef ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      c_q     <= c_d;
`ifdef ALU_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: FSM, single-cycle ops and flag logic; shifts/multiply run in alu_iter_unit.
// Define ALU_MUL_EN to build the opcode-9 unsigned multiplier (otherwise opcode 9 acts as PASS).
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   Sel_ALU,
  input  logic [N-1:0] RX,
  input  logic [N-1:0] RY,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] R0,
  output logic [3:0]   Flags,
  output logic         busy
);

  localparam int SW = $clog2(N);
  localparam int CW = SW + 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and R0/Flags never change in DONE.
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  r0_q, r0_d;
  logic [3:0]    flags_q, flags_d;

  logic          iter_start, iter_done, iter_carry;
  logic [1:0]    iter_mode;
  logic [CW-1:0] iter_cnt;
  logic [N-1:0]  iter_result;
  logic [N-1:0]  res;
  logic          c, v, finish;
  logic [SW-1:0] amt;

  assign amt = RY[SW-1:0];

  alu_iter_unit #(.N(N), .CW(CW)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (iter_start),
    .mode     (iter_mode),
    .a        (RX),
    .b        (RY),
    .cnt_init (iter_cnt),
    .done     (iter_done),
    .result   (iter_result),
    .carry    (iter_carry)
  );

  always_comb begin
    state_d    = state_q;
    r0_d       = r0_q;
    flags_d    = flags_q;
    iter_start = 1'b0;
    iter_mode  = ITER_SHL;
    iter_cnt   = '0;
    res        = RX;
    c          = 1'b0;
    v          = 1'b0;
    finish     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (Sel_ALU)
            OP_ADD: begin
              {c, res} = {1'b0, RX} + {1'b0, RY};
              v = (RX[N-1] == RY[N-1]) && (res[N-1] != RX[N-1]);
            end
            OP_SUB: begin
              {c, res} = {1'b0, RY} - {1'b0, RX};
              v = (RY[N-1] != RX[N-1]) && (res[N-1] != RY[N-1]);
            end
            OP_SHL, OP_SHR: begin
              // A zero amount completes like a single-cycle op with R0 = RX, C = 0.
              if (amt != '0) begin
                iter_start = 1'b1;
                iter_mode  = (Sel_ALU == OP_SHL) ? ITER_SHL : ITER_SHR;
                iter_cnt   = {1'b0, amt};
              end
            end
            OP_NOT: res = ~RX;
            OP_AND: res = RX & RY;
            OP_OR:  res = RX | RY;
            OP_XOR: res = RX ^ RY;
`ifdef ALU_MUL_EN
            OP_MUL: begin
              iter_start = 1'b1;
              iter_mode  = ITER_MUL;
              iter_cnt   = CW'(N);
            end
`endif
            default: res = RX;
          endcase
          if (iter_start) state_d = ST_EXEC;
          else            finish  = 1'b1;
        end
      end
      ST_EXEC: begin
        if (iter_done) begin
          res    = iter_result;
          c      = iter_carry;
          finish = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (finish) begin
      state_d         = ST_DONE;
      r0_d            = res;
      flags_d[FLAG_Z] = (res == '0);
      flags_d[FLAG_S] = res[N-1];
      flags_d[FLAG_C] = c;
      flags_d[FLAG_V] = v;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r0_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_EXEC);
  assign R0        = r0_q;
  assign Flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed spec vectors, backpressure, abort and random back-to-back ops.
module tb_alu_seq;

  localparam int N    = 8;
  localparam int W    = N + 4;
  localparam int HALF = 1 << (N - 1);
  localparam int FULL = 1 << N;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Sel_ALU;
  logic [N-1:0] RX;
  logic [N-1:0] RY;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] R0;
  logic [3:0]   Flags;
  logic         busy;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Sel_ALU   (Sel_ALU),
    .RX        (RX),
    .RY        (RY),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R0        (R0),
    .Flags     (Flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: {V,S,C,Z, R0} computed with integer arithmetic.
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    logic [N-1:0] r;
    logic c, v;
    int ux, uy, sx, sy, t, amt;
    longint p;
    ux  = int'(x);
    uy  = int'(y);
    sx  = (ux >= HALF) ? ux - FULL : ux;
    sy  = (uy >= HALF) ? uy - FULL : uy;
    amt = uy % N;
    r = x; c = 1'b0; v = 1'b0; p = 0;
    case (op)
      4'd0: begin t = ux + uy; r = N'(t); c = (t >= FULL); v = ((sx + sy) >= HALF) || ((sx + sy) < -HALF); end
      4'd1: begin t = uy - ux; r = N'(t); c = (uy < ux);   v = ((sy - sx) >= HALF) || ((sy - sx) < -HALF); end
      4'd2: begin t = ux << amt; r = N'(t); c = (amt != 0) && t[N]; end
      4'd3: begin r = x >> amt; c = (amt != 0) && x[amt-1]; end
      4'd4: r = ~x;
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
`ifdef ALU_MUL_EN
      4'd9: begin p = longint'(ux) * longint'(uy); r = N'(p); c = ((p >> N) != 0); end
`endif
      default: r = x;
    endcase
    return {v, r[N-1], c, (r == '0), r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [N-1:0] y);
    if (op == 4'd2 || op == 4'd3) return (int'(y) % N) + 1;
`ifdef ALU_MUL_EN
    if (op == 4'd9) return N + 1;
`endif
    return 1;
  endfunction

  // Driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] x, input logic [N-1:0] y,
                        input int bp, output logic [W-1:0] got, output int lat,
                        output int busy_n, output logic [W-1:0] after, output logic ov_after);
    Sel_ALU  = op;
    RX       = x;
    RY       = y;
    in_valid = 1'b1;
    exp_q.push_back(model(op, x, y));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Sel_ALU  = 4'($urandom_range(15, 0));
    RX       = N'($urandom);
    RY       = N'($urandom);
    lat = 0;
    busy_n = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy) busy_n++;
    end
    repeat (bp) @(negedge clk);
    got = out_valid ? {Flags, R0} : 'x;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    after    = {Flags, R0};
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, busy, R0, Flags} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ov=%b busy=%b R0=%h Flags=%h expected all zero", out_valid, busy, R0, Flags);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] got, after, e;
    logic ov;
    int lat, bn;
    run_op(4'd0, 8'h7F, 8'h01, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL add_model: got %h expected %h", got, e); end
    n_cmp++;
    if (got !== {4'b1100, 8'h80}) begin n_err++; $display("FAIL add_vector: got %h expected %h", got, {4'b1100, 8'h80}); end
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (ov !== 1'b0 || after !== got) begin
      n_err++;
      $display("FAIL add_after_handshake: got ov=%b hold=%h expected ov=0 hold=%h", ov, after, got);
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] got, after, e;
    logic [W-1:0] lit [2];
    logic [N-1:0] xs [2];
    logic [N-1:0] ys [2];
    logic ov;
    int lat, bn;
    xs[0] = 8'h05; ys[0] = 8'h05; lit[0] = {4'b0001, 8'h00};
    xs[1] = 8'h05; ys[1] = 8'h03; lit[1] = {4'b0110, 8'hFE};
    for (int i = 0; i < 2; i++) begin
      run_op(4'd1, xs[i], ys[i], 0, got, lat, bn, after, ov);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || got !== lit[i]) begin
        n_err++;
        $display("FAIL sub_vector%0d: got %h expected %h", i, got, lit[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] got, after, e;
    logic ov;
    int lat, bn;
    run_op(4'd2, 8'h81, 8'h03, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || got[N-1:0] !== 8'h08 || got[N+1] !== 1'b0) begin
      n_err++; $display("FAIL shl3_result: got %h expected %h", got, e);
    end
    n_cmp++;
    if (lat !== 4 || bn !== 3) begin
      n_err++; $display("FAIL shl3_timing: got lat=%0d busy=%0d expected lat=4 busy=3", lat, bn);
    end
    run_op(4'd2, 8'h81, 8'h00, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || got !== {4'b0100, 8'h81} || lat !== 1) begin
      n_err++; $display("FAIL shl0: got %h lat=%0d expected %h lat=1", got, lat, {4'b0100, 8'h81});
    end
    run_op(4'd3, 8'h96, 8'h02, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || lat !== 3) begin
      n_err++; $display("FAIL shr2: got %h lat=%0d expected %h lat=3", got, lat, e);
    end
    run_op(4'd3, 8'h80, 8'hF7, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || lat !== 8) begin
      n_err++; $display("FAIL shr7: got %h lat=%0d expected %h lat=8", got, lat, e);
    end
  endtask

  task automatic test_logic();
    logic [W-1:0] got, after, e;
    logic ov;
    int lat, bn;
    for (int op = 4; op < 16; op++) begin
      if (op == 9) continue;
      run_op(4'(op), 8'hA5, 8'h3C, 0, got, lat, bn, after, ov);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || lat !== 1) begin
        n_err++; $display("FAIL logic_op%0d: got %h lat=%0d expected %h lat=1", op, got, lat, e);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] got, after, e;
    logic ov;
    int lat, bn;
    run_op(4'd9, 8'h10, 8'h11, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || got[N-1:0] !== 8'h10) begin
      n_err++; $display("FAIL mul_result: got %h expected %h", got, e);
    end
    n_cmp++;
    if (lat !== exp_lat(4'd9, 8'h11)) begin
      n_err++; $display("FAIL mul_latency: got %0d expected %0d", lat, exp_lat(4'd9, 8'h11));
    end
    run_op(4'd9, 8'hFF, 8'hFF, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL mul_ffxff: got %h expected %h", got, e); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    Sel_ALU = 4'd0; RX = 8'h12; RY = 8'hF4; in_valid = 1'b1;
    exp_q.push_back(model(4'd0, 8'h12, 8'hF4));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, Flags, R0} !== {2'b10, e}) begin
        n_err++;
        $display("FAIL backpressure_c%0d: got ov=%b ir=%b %h expected ov=1 ir=0 %h", i, out_valid, in_ready, {Flags, R0}, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready, Flags, R0} !== {2'b01, e}) begin
      n_err++;
      $display("FAIL backpressure_release: got ov=%b ir=%b %h expected ov=0 ir=1 %h", out_valid, in_ready, {Flags, R0}, e);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] got, after, e;
    logic ov;
    int lat, bn;
    // Reset while a result is waiting in DONE.
    Sel_ALU = 4'd0; RX = 8'h7F; RY = 8'h01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, R0, Flags} !== '0) begin
      n_err++;
      $display("FAIL abort_done: got ov=%b busy=%b R0=%h Flags=%h expected all zero", out_valid, busy, R0, Flags);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Leave a non-zero result behind, then reset in the middle of a 7-bit shift.
    run_op(4'd7, 8'hC3, 8'h0F, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin n_err++; $display("FAIL abort_pre_xor: got %h expected %h", got, e); end
    Sel_ALU = 4'd2; RX = 8'hFF; RY = 8'h07; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy: got %b expected 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, R0, Flags} !== '0) begin
      n_err++;
      $display("FAIL abort_exec: got ov=%b busy=%b R0=%h Flags=%h expected all zero", out_valid, busy, R0, Flags);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, R0} !== {2'b10, 8'h00}) begin
      n_err++;
      $display("FAIL abort_no_partial: got ir=%b ov=%b R0=%h expected ir=1 ov=0 R0=00", in_ready, out_valid, R0);
    end
    run_op(4'd5, 8'hF0, 8'h3C, 0, got, lat, bn, after, ov);
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e || got !== {4'b0000, 8'h30} || lat !== 1) begin
      n_err++; $display("FAIL abort_next_and: got %h lat=%0d expected %h lat=1", got, lat, {4'b0000, 8'h30});
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got, after, e;
    logic [3:0] op;
    logic [N-1:0] x, y;
    logic ov;
    int lat, bn;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(15, 0));
      x  = N'($urandom);
      y  = N'($urandom);
      run_op(op, x, y, $urandom_range(2, 0), got, lat, bn, after, ov);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e || lat !== exp_lat(op, y) || ov !== 1'b0 || after !== got) begin
        n_err++;
        $display("FAIL b2b_%0d op=%0d x=%h y=%h: got %h lat=%0d ov=%b expected %h lat=%0d ov=0",
                 i, op, x, y, got, lat, ov, e, exp_lat(op, y));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Sel_ALU = '0;
    RX = '0;
    RY = '0;
    #3;
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_logic();
    test_mul();
    test_backpressure();
    test_abort();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
